updowncount_ctrl: RTL and testbench



---
 rtl/udc_pkg.sv | 36 +++
 rtl/udc_dwell_timer.sv | 37 +++
 rtl/updowncount_ctrl.sv | 163 ++++++++++++++++
 tb/tb_updowncount_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : udc_pkg                                                |
// | Description : Shared types and constants for the up/down counter     |
// |               sequencing controller (state encoding, direction       |
// |               constants, default widths, state helper).              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package udc_pkg;

  localparam int UDC_N_DEFAULT     = 8;
  localparam int UDC_RW_DEFAULT    = 4;
  localparam int UDC_DWELL_DEFAULT = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // HOLD_HI / HOLD_LO are only reachable when the dwell feature is built in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    UP      = 3'd2,
    DOWN    = 3'd3,
    DONE    = 3'd4,
    HOLD_HI = 3'd5,
    HOLD_LO = 3'd6
  } udc_state_t;

  // A run is in progress (drives busy).
  function automatic logic is_active(input udc_state_t s);
    return (s == LOAD) || (s == UP) || (s == DOWN) ||
           (s == HOLD_HI) || (s == HOLD_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/udc_dwell_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : udc_dwell_timer                                        |
// | Description : Loadable down-counter with an expiry strobe, used to   |
// |               hold the counter at each turning point.                |
// |               Compiled only when UDC_DWELL_EN is defined.            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`ifdef UDC_DWELL_EN
module udc_dwell_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;

  // Reload while idle; count down to zero and stick there while holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule
`endif
`default_nettype wire

// File: rtl/updowncount_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : updowncount_ctrl                                       |
// | Description : Sequencer for the n-bit up/down counter: loads lo,     |
// |               counts up to hi and back to lo for a programmed number |
// |               of rounds, with busy/done/err status.                  |
// |               Optional macro UDC_DWELL_EN adds DWELL-cycle holds at  |
// |               each turning point.                                    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module updowncount_ctrl
  import udc_pkg::*;
#(
  parameter int n     = UDC_N_DEFAULT,
  parameter int RW    = UDC_RW_DEFAULT,
  parameter int DWELL = UDC_DWELL_DEFAULT
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          start,
  input  logic          stop,
  input  logic [n-1:0]  lo,
  input  logic [n-1:0]  hi,
  input  logic [RW-1:0] rounds,
  input  logic [n-1:0]  Q,
  output logic [n-1:0]  R,
  output logic          L,
  output logic          E,
  output logic          up_down,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] round_cnt
);

  udc_state_t    r_state;
  udc_state_t    w_next;
  logic [n-1:0]  r_lo;
  logic [n-1:0]  r_hi;
  logic [RW-1:0] r_rounds;
  logic [RW-1:0] r_round_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_bad;
  logic          w_at_top;
  logic          w_at_bot;
  logic          w_last;
  logic [RW-1:0] w_rc_inc;
  logic          w_dwell_done;

  assign w_accept = (r_state == IDLE) && start && !stop;
  assign w_bad    = (hi <= lo);
  // Turn one step early so the counter's next edge lands exactly on the bound.
  assign w_at_top = (Q == (r_hi - n'(1)));
  assign w_at_bot = (Q == (r_lo + n'(1)));
  assign w_rc_inc = r_round_cnt + RW'(1);
  assign w_last   = (r_rounds != '0) && (w_rc_inc == r_rounds);

`ifdef UDC_DWELL_EN
  localparam udc_state_t c_after_top = HOLD_HI;
  localparam udc_state_t c_after_bot = HOLD_LO;
  localparam int         c_dw_w      = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic w_in_hold;
  assign w_in_hold = (r_state == HOLD_HI) || (r_state == HOLD_LO);

  udc_dwell_timer #(
    .WIDTH (c_dw_w)
  ) u_dwell (
    .clk        (Clock),
    .rst_n      (Resetn),
    .i_load     (!w_in_hold),
    .i_load_val (c_dw_w'(DWELL - 1)),
    .o_expired  (w_dwell_done)
  );
`else
  localparam udc_state_t c_after_top = DOWN;
  localparam udc_state_t c_after_bot = UP;
  assign w_dwell_done = 1'b0;
`endif

  // State register and registered status/latched bounds.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_rounds    <= '0;
      r_round_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= is_active(w_next);
      r_done  <= (w_next == DONE);
      if (w_accept) begin
        r_lo        <= lo;
        r_hi        <= hi;
        r_rounds    <= rounds;
        r_round_cnt <= '0;
        r_err       <= w_bad;
      end else if ((r_state == DOWN) && !stop && w_at_bot) begin
        r_round_cnt <= w_rc_inc;
      end
    end
  end

  // Next-state decode; stop has priority over every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_bad ? DONE : LOAD;
      end
      LOAD: begin
        w_next = stop ? IDLE : UP;
      end
      UP: begin
        if (stop)          w_next = IDLE;
        else if (w_at_top) w_next = c_after_top;
      end
      DOWN: begin
        if (stop)          w_next = IDLE;
        else if (w_at_bot) w_next = w_last ? DONE : c_after_bot;
      end
      DONE: begin
        w_next = IDLE;
      end
`ifdef UDC_DWELL_EN
      HOLD_HI: begin
        if (stop)              w_next = IDLE;
        else if (w_dwell_done) w_next = DOWN;
      end
      HOLD_LO: begin
        if (stop)              w_next = IDLE;
        else if (w_dwell_done) w_next = UP;
      end
`endif
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Counter controls decode directly from the registered state.
  always_comb begin
    L       = (r_state == LOAD);
    E       = (r_state == UP) || (r_state == DOWN);
    up_down = (r_state == DOWN) ? DIR_DOWN : DIR_UP;
  end

  assign R         = r_lo;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign round_cnt = r_round_cnt;

endmodule
`default_nettype wire

// File: tb/tb_updowncount_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_updowncount_ctrl                                    |
// | Description : Closed-loop bench: controller driving a behavioural    |
// |               n-bit up/down counter, with a Q-sequence scoreboard.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_updowncount_ctrl;

  localparam int N  = 8;
  localparam int RN = 4;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          stop;
  logic [N-1:0]  lo;
  logic [N-1:0]  hi;
  logic [RN-1:0] rounds;
  logic [N-1:0]  q = '0;
  logic [N-1:0]  R;
  logic          L, E, up_down, busy, done, err;
  logic [RN-1:0] round_cnt;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] sb[$];
  bit           mon_en = 1'b0;
  bit           mon_overrun = 1'b0;
  logic         prev_e = 1'b0;
  int           done_cnt = 0;
  int           e_cnt = 0;

  updowncount_ctrl #(.n(N), .RW(RN), .DWELL(DW)) dut (
    .Clock(clk), .Resetn(resetn), .start(start), .stop(stop),
    .lo(lo), .hi(hi), .rounds(rounds), .Q(q), .R(R), .L(L), .E(E),
    .up_down(up_down), .busy(busy), .done(done), .err(err),
    .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of the existing updowncount counter.
  always @(posedge clk) begin
    if (L)      q <= R;
    else if (E) q <= up_down ? q + 8'd1 : q - 8'd1;
  end

  // Scoreboard monitor: Q is checked on every counting cycle and on the
  // first cycle after counting stops.
  initial begin
    logic [N-1:0] exp_q;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (E) e_cnt++;
      if (mon_en && (E || prev_e)) begin
        if (sb.size() == 0) begin
          if (!mon_overrun) begin
            tests++; fails++;
            $display("FAIL sb_extra: Q=%0d observed with no expected value", q);
          end
        end else begin
          exp_q = sb.pop_front();
          tests++;
          if (q !== exp_q) begin
            fails++;
            $display("FAIL sb_q: Q=%0d expected %0d", q, exp_q);
          end
        end
      end
      prev_e = E;
    end
  end

  // Expected Q trace for a run of nr rounds between lo and hi.
  function automatic void push_seq(input int l, input int h, input int nr, input bit fin);
    for (int r = 0; r < nr; r++) begin
      for (int v = l; v < h; v++) sb.push_back(N'(v));
`ifdef UDC_DWELL_EN
      sb.push_back(N'(h));
`endif
      for (int v = h; v > l; v--) sb.push_back(N'(v));
`ifdef UDC_DWELL_EN
      if (r < nr - 1) sb.push_back(N'(l));
`endif
    end
    if (fin) sb.push_back(N'(l));
  endfunction

  task automatic do_start(input int l, input int h, input int nr);
    @(negedge clk);
    lo = N'(l); hi = N'(h); rounds = RN'(nr); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!busy && !done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; lo = '0; hi = '0; rounds = '0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (L !== 1'b0)       begin fails++; $display("FAIL rst_L: got %0b want 0", L); end
    tests++; if (E !== 1'b0)       begin fails++; $display("FAIL rst_E: got %0b want 0", E); end
    tests++; if (up_down !== 1'b1) begin fails++; $display("FAIL rst_up_down: got %0b want 1", up_down); end
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL rst_done: got %0b want 0", done); end
    tests++; if (err !== 1'b0)     begin fails++; $display("FAIL rst_err: got %0b want 0", err); end
    tests++; if (round_cnt !== '0) begin fails++; $display("FAIL rst_round_cnt: got %0d want 0", round_cnt); end
    tests++; if (R !== '0)         begin fails++; $display("FAIL rst_R: got %0d want 0", R); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single_round;
    bit to; int d0;
    d0 = done_cnt; mon_en = 1'b1;
    push_seq(2, 5, 1, 1'b1);
    do_start(2, 5, 1);
    wait_idle(100, to);
    tests++; if (to !== 1'b0)       begin fails++; $display("FAIL single_timeout: run did not finish"); end
    tests++; if (sb.size() != 0)    begin fails++; $display("FAIL single_sb_left: %0d values left want 0", sb.size()); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL single_done: %0d pulses want 1", done_cnt - d0); end
    tests++; if (round_cnt !== 4'd1) begin fails++; $display("FAIL single_rounds: got %0d want 1", round_cnt); end
    repeat (3) @(negedge clk);
    #1;
    tests++; if (q !== 8'd2)        begin fails++; $display("FAIL single_q_hold: got %0d want 2", q); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL single_busy: got %0b want 0", busy); end
  endtask

  task automatic test_toggle;
    bit to; int d0;
    d0 = done_cnt;
    push_seq(0, 1, 3, 1'b1);
    do_start(0, 1, 3);
    wait_idle(100, to);
    tests++; if (to !== 1'b0)        begin fails++; $display("FAIL toggle_timeout: run did not finish"); end
    tests++; if (sb.size() != 0)     begin fails++; $display("FAIL toggle_sb_left: %0d values left want 0", sb.size()); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL toggle_done: %0d pulses want 1", done_cnt - d0); end
    tests++; if (round_cnt !== 4'd3) begin fails++; $display("FAIL toggle_rounds: got %0d want 3", round_cnt); end
    tests++; if (q !== 8'd0)         begin fails++; $display("FAIL toggle_q: got %0d want 0", q); end
  endtask

  task automatic test_bad_bounds;
    bit to; int d0, e0;
    d0 = done_cnt; e0 = e_cnt;
    do_start(7, 7, 1);
    wait_idle(20, to);
    tests++; if (err !== 1'b1)        begin fails++; $display("FAIL bad_eq_err: got %0b want 1", err); end
    tests++; if (done_cnt - d0 != 1)  begin fails++; $display("FAIL bad_eq_done: %0d pulses want 1", done_cnt - d0); end
    tests++; if (e_cnt != e0)         begin fails++; $display("FAIL bad_eq_enable: E high %0d cycles want 0", e_cnt - e0); end
    tests++; if (round_cnt !== '0)    begin fails++; $display("FAIL bad_eq_rounds: got %0d want 0", round_cnt); end
    do_start(9, 4, 2);
    wait_idle(20, to);
    tests++; if (err !== 1'b1)        begin fails++; $display("FAIL bad_lt_err: got %0b want 1", err); end
    tests++; if (e_cnt != e0)         begin fails++; $display("FAIL bad_lt_enable: E high %0d cycles want 0", e_cnt - e0); end
    push_seq(1, 3, 1, 1'b1);
    do_start(1, 3, 1);
    tests++; if (err !== 1'b0)        begin fails++; $display("FAIL bad_clear_err: got %0b want 0", err); end
    wait_idle(100, to);
    tests++; if (sb.size() != 0)      begin fails++; $display("FAIL bad_clear_sb_left: %0d values left want 0", sb.size()); end
    tests++; if (round_cnt !== 4'd1)  begin fails++; $display("FAIL bad_clear_rounds: got %0d want 1", round_cnt); end
  endtask

  task automatic test_start_stop_together;
    @(negedge clk);
    lo = 8'd1; hi = 8'd4; rounds = 4'd1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL startstop_busy: got %0b want 0", busy); end
    tests++; if (L !== 1'b0)    begin fails++; $display("FAIL startstop_L: got %0b want 0", L); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL startstop_done: got %0b want 0", done); end
    tests++; if (R !== 8'd1)    begin fails++; $display("FAIL startstop_R: got %0d want 1 (previous lo)", R); end
  endtask

  task automatic test_continuous_stop;
    bit hit; int d0;
    mon_overrun = 1'b1;
    push_seq(250, 255, 2, 1'b0);
    do_start(250, 255, 0);
    // Mid-run start with new bounds must be ignored.
    repeat (2) @(negedge clk);
    lo = 8'd0; hi = 8'd100; rounds = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin @(negedge clk); #1; end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL cont_sb_left: %0d values left want 0", sb.size()); end
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (E && up_down && q == 8'd252) begin hit = 1'b1; break; end
      @(negedge clk); #1;
    end
    tests++; if (!hit) begin fails++; $display("FAIL cont_reach_252: not seen, want seen"); end
    d0 = done_cnt;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #1;
    tests++; if (E !== 1'b0)     begin fails++; $display("FAIL stop_E: got %0b want 0", E); end
    tests++; if (q !== 8'd253)   begin fails++; $display("FAIL stop_q: got %0d want 253", q); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL stop_busy: got %0b want 0", busy); end
    repeat (3) @(negedge clk);
    #1;
    tests++; if (q !== 8'd253)        begin fails++; $display("FAIL stop_q_frozen: got %0d want 253", q); end
    tests++; if (done_cnt != d0)      begin fails++; $display("FAIL stop_no_done: %0d pulses want 0", done_cnt - d0); end
    tests++; if (round_cnt !== 4'd2)  begin fails++; $display("FAIL stop_rounds: got %0d want 2", round_cnt); end
    tests++; if (err !== 1'b0)        begin fails++; $display("FAIL cont_err: got %0b want 0", err); end
    mon_overrun = 1'b0;
  endtask

  task automatic test_reset_mid_down;
    bit to, hit; int d0;
    mon_en = 1'b0; sb.delete();
    do_start(2, 6, 1);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (E && !up_down) begin hit = 1'b1; break; end
    end
    tests++; if (!hit) begin fails++; $display("FAIL rmid_reach_down: not seen, want seen"); end
    #2 resetn = 1'b0;
    #1;
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    tests++; if (E !== 1'b0)         begin fails++; $display("FAIL rmid_E: got %0b want 0", E); end
    tests++; if (up_down !== 1'b1)   begin fails++; $display("FAIL rmid_up_down: got %0b want 1", up_down); end
    tests++; if (round_cnt !== '0)   begin fails++; $display("FAIL rmid_rounds: got %0d want 0", round_cnt); end
    tests++; if (R !== '0)           begin fails++; $display("FAIL rmid_R: got %0d want 0", R); end
    @(negedge clk);
    resetn = 1'b1;
    d0 = done_cnt; mon_en = 1'b1;
    push_seq(1, 3, 1, 1'b1);
    do_start(1, 3, 1);
    wait_idle(100, to);
    tests++; if (sb.size() != 0)      begin fails++; $display("FAIL rmid_restart_sb: %0d values left want 0", sb.size()); end
    tests++; if (done_cnt - d0 != 1)  begin fails++; $display("FAIL rmid_restart_done: %0d pulses want 1", done_cnt - d0); end
    tests++; if (round_cnt !== 4'd1)  begin fails++; $display("FAIL rmid_restart_rounds: got %0d want 1", round_cnt); end
  endtask

`ifdef UDC_DWELL_EN
  task automatic test_dwell;
    int hold, d0; bit fin;
    d0 = done_cnt; hold = 0; fin = 1'b0;
    push_seq(1, 3, 1, 1'b1);
    do_start(1, 3, 1);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (busy && !E && !L && q == 8'd3) hold++;
      if (!busy && !done) begin fin = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!fin)               begin fails++; $display("FAIL dwell_timeout: run did not finish"); end
    tests++; if (hold != DW)         begin fails++; $display("FAIL dwell_hold: %0d cycles want %0d", hold, DW); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL dwell_done: %0d pulses want 1", done_cnt - d0); end
    tests++; if (q !== 8'd1)         begin fails++; $display("FAIL dwell_q: got %0d want 1", q); end
    tests++; if (sb.size() != 0)     begin fails++; $display("FAIL dwell_sb_left: %0d values left want 0", sb.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_round();
    test_toggle();
    test_bad_bounds();
    test_start_stop_together();
    test_continuous_stop();
    test_reset_mid_down();
`ifdef UDC_DWELL_EN
    test_dwell();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
